tt_sweep_checker: RTL
=====================

Name: tt_sweep_checker

Overview:
- Sequential stimulus/capture stage wrapped around one combinational 3-input logic-circuit netlist (NOR/NOT gate level).
- On `start` it drives all 8 input combinations onto the circuit and waits a programmable settle time per row. It then samples the circuit output and assembles the 8-bit truth-table hex value.
- It compares that value with an expected code, e.g. 0xA1, and reports pass/fail. Used by the circuit-scoring test flow to confirm that each generated design implements its target function.

Parameters:
- SETTLE_CYCLES, 2, cycles held per row before the sample cycle; legal 0..255.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a sweep in progress.
- expected  input  8  target truth table; latched when start is accepted.
- dut_out  input  1  output of the circuit under test.
- in1  output  1  circuit input, row-index bit 2 (MSB).
- in2  output  1  circuit input, row-index bit 1.
- in3  output  1  circuit input, row-index bit 0 (LSB).
- busy  output  1  high from accepted start until done or abort.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  captured == expected_latched; valid from done, held until next accepted start.
- captured  output  8  assembled truth table.
- mismatch_mask  output  8  captured XOR expected_latched; same validity as pass.

Behaviour:
- Reset (rst_n low at an edge) sets: state IDLE; in1..in3 = 0; busy, done, pass = 0; captured = 0x00; mismatch_mask = 0x00; row = 0; settle counter = 0; expected_latched = 0x00. Reset mid-sweep aborts immediately, with no done.
- Row encoding: row r = {in1, in2, in3}. The sample for row r is written to captured[7-r], so row 0 is the MSB. Example: a circuit whose output is ~in1 when in3=0 and in1&in2 when in3=1 yields 0xA1.
- IDLE state:
  - Outputs in1..in3 = 000 and busy = 0.
  - When start = 1 and abort = 0: latch expected, clear captured, pass and mismatch_mask, set row = 0, drive vector 000, clear counter, set busy = 1, go to SETTLE.
  - If start and abort are both high, abort wins and the block stays IDLE.
- SETTLE state:
  - The vector is held and the counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
  - If SETTLE_CYCLES = 0, go straight from the start edge, or the previous sample edge, to SAMPLE.
- SAMPLE state (one cycle):
  - At the closing edge, dut_out is registered into captured[7-row].
  - If row = 7: compute pass and mismatch_mask from the final captured value in the same edge, set done = 1, go to DONE.
  - Otherwise: row increments, the new vector is driven from that same edge, the counter clears, and the state returns to SETTLE.
- DONE state (one cycle):
  - done = 1 and busy = 0; in1..in3 return to 000 at the edge leaving DONE.
  - The next state is always IDLE. A start during DONE is ignored.
- Per-row cost is SETTLE_CYCLES+1 cycles. done is high in cycle 8*(SETTLE_CYCLES+1), counting the edge that accepts start as cycle 0. With the default of 2, that is cycle 24.
- Start while busy is ignored. Any change to expected after acceptance has no effect.
- Abort in SETTLE or SAMPLE:
  - Next edge: IDLE, busy = 0, in1..in3 = 000, no done pulse.
  - captured keeps its partial bits; pass = 0 and mismatch_mask = 0x00.
- dut_out is treated as settled by the sample edge. Any flop delay inside the tested path must be covered by SETTLE_CYCLES.

Test Plan:
- Ideal 0xA1 gate model on dut_out, expected = 0xA1, default settle → vectors 000..111 in order, done in cycle 24, captured = 0xA1, pass = 1, mismatch_mask = 0x00.
- Same model, expected = 0xA0 → captured = 0xA1, pass = 0, mismatch_mask = 0x01. Then a second run with expected = 0xA1 → pass = 1; pass was cleared to 0 at the second start.
- dut_out tied to 0, expected = 0xA1 → captured = 0x00, pass = 0, mismatch_mask = 0xA1.
- SETTLE_CYCLES = 0 build, 0xA1 model → done in cycle 8, captured = 0xA1. Same build with the model behind 1 flop → captured differs from 0xA1, pass = 0.
- Abort asserted while row = 3 → next cycle busy = 0, in1..in3 = 000, no done pulse. A start pulsed during that abort cycle and during the earlier busy cycles is ignored. start+abort in IDLE → stays IDLE.
- rst_n low for one edge at row 5 → every output at its reset value the following cycle. A fresh start then completes normally with captured = 0xA1.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: walks a 3-input circuit through all 8 rows,
// samples its output per row and compares the assembled code with a target.
module tt_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] captured_q, captured_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] cap_sample;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        captured_d = captured_q;
        mask_d     = mask_q;
        exp_d      = exp_q;

        // Row 0 lands in the MSB, so the row index counts down from bit 7.
        cap_sample               = captured_q;
        cap_sample[3'd7 - row_q] = dut_out;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    exp_d      = expected;
                    captured_d = 8'h00;
                    pass_d     = 1'b0;
                    mask_d     = 8'h00;
                    row_d      = 3'd0;
                    vec_d      = 3'd0;
                    cnt_d      = 8'd0;
                    busy_d     = 1'b1;
                    state_d    = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                captured_d = cap_sample;
                if (row_q == 3'd7) begin
                    pass_d  = (cap_sample == exp_q);
                    mask_d  = cap_sample ^ exp_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 3'd1;
                    vec_d   = row_q + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            DONE: begin
                vec_d   = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort discards the in-flight sample but keeps bits already captured.
        if (abort && (state_q == SETTLE || state_q == SAMPLE)) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            vec_d      = 3'd0;
            row_d      = 3'd0;
            cnt_d      = 8'd0;
            pass_d     = 1'b0;
            mask_d     = 8'h00;
            done_d     = 1'b0;
            captured_d = captured_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= 3'd0;
            cnt_q      <= 8'd0;
            vec_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 8'h00;
            mask_q     <= 8'h00;
            exp_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            mask_q     <= mask_d;
            exp_q      <= exp_d;
        end
    end

    assign {in1, in2, in3} = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured        = captured_q;
    assign mismatch_mask   = mask_q;

endmodule
